// File: rtl/cam_gray_framer.sv
// Camera front end: RGB565 to DataDepth-bit grey with raster coordinates, frame markers,
// a frame-buffer write-address reset pulse and a small output FIFO that absorbs stalls.
module cam_gray_framer #(
  parameter int CameraDataDepth = 16,
  parameter int DataDepth       = 4,
  parameter int ImageW          = 8,
  parameter int ImageH          = 8,
  parameter int FifoDepth       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cam_dv,
  input  logic [CameraDataDepth-1:0] cam_data,
  input  logic                       cam_vsync,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [DataDepth-1:0]       pix_data,
  output logic [$clog2(ImageW)-1:0]  pix_x,
  output logic [$clog2(ImageH)-1:0]  pix_y,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic                       fb_wr_rst,
  output logic                       ovf_err,
  output logic [7:0]                 frame_cnt
);

  localparam int XW = $clog2(ImageW);
  localparam int YW = $clog2(ImageH);
  localparam int AW = $clog2(FifoDepth);
  localparam int EW = DataDepth + XW + YW + 2;

  // Weights sum to 32, so the 11-bit sum never overflows and the result fits 6 bits.
  function automatic logic [5:0] luma6(input logic [5:0] r6, input logic [5:0] g6,
                                       input logic [5:0] b6);
    logic [10:0] sum;
    sum = 11'd9 * 11'(r6) + 11'd19 * 11'(g6) + 11'd4 * 11'(b6);
    return sum[10:5];
  endfunction

  function automatic logic [DataDepth-1:0] to_depth(input logic [5:0] y6);
    return y6[5 -: DataDepth];
  endfunction

  logic [XW-1:0] x_cnt, cur_x;
  logic [YW-1:0] y_cnt, cur_y;
  logic          sof_pending;
  logic          last_x, last_y, wrap, cur_sof;

  always_comb begin
    cur_x   = cam_vsync ? '0 : x_cnt;
    cur_y   = cam_vsync ? '0 : y_cnt;
    cur_sof = cam_vsync | sof_pending;
    last_x  = (cur_x == XW'(ImageW - 1));
    last_y  = (cur_y == YW'(ImageH - 1));
    wrap    = cam_dv & last_x & last_y;
  end

  // A completed frame is counted on its last pixel; vsync after it only restarts addressing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      sof_pending <= 1'b1;
      frame_cnt   <= '0;
      fb_wr_rst   <= 1'b0;
    end else begin
      fb_wr_rst <= cam_vsync | wrap;
      if (cam_dv) begin
        sof_pending <= wrap;
        if (last_x) begin
          x_cnt <= '0;
          if (last_y) begin
            y_cnt     <= '0;
            frame_cnt <= frame_cnt + 8'd1;
          end else begin
            y_cnt <= cur_y + 1'b1;
          end
        end else begin
          x_cnt <= cur_x + 1'b1;
          y_cnt <= cur_y;
        end
      end else if (cam_vsync) begin
        x_cnt       <= '0;
        y_cnt       <= '0;
        sof_pending <= 1'b1;
      end
    end
  end

  // ---- stage 1: expanded colour components and pixel tags ----
  logic          vld_p1;
  logic [5:0]    r6_p1, g6_p1, b6_p1;
  logic [XW-1:0] x_p1;
  logic [YW-1:0] y_p1;
  logic          sof_p1, eol_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= cam_dv;
  end

  always_ff @(posedge clk) begin
    if (cam_dv) begin
      r6_p1  <= {cam_data[15:11], cam_data[15]};
      g6_p1  <= cam_data[10:5];
      b6_p1  <= {cam_data[4:0], cam_data[4]};
      x_p1   <= cur_x;
      y_p1   <= cur_y;
      sof_p1 <= cur_sof;
      eol_p1 <= last_x;
    end
  end

  // ---- stage 2: grey value registered straight into the fall-through FIFO ----
  logic [EW-1:0] mem [FifoDepth];
  logic [EW-1:0] entry_p2;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          full, rd, wr;

  assign entry_p2  = {sof_p1, eol_p1, y_p1, x_p1, to_depth(luma6(r6_p1, g6_p1, b6_p1))};
  assign full      = (cnt == (AW + 1)'(FifoDepth));
  assign pix_valid = (cnt != '0);
  assign rd        = pix_valid & pix_ready;
  assign wr        = vld_p1 & (~full | rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (vld_p1 & full & ~rd) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= entry_p2;
  end

  // Storage is never cleared; gating on pix_valid keeps the outputs at zero while empty.
  assign {pix_sof, pix_eol, pix_y, pix_x, pix_data} = pix_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_cam_gray_framer.sv
// Directed bench for cam_gray_framer (default parameters: 8x8 image, 4-bit grey, 4-entry FIFO).
module tb_cam_gray_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cam_dv;
  logic [15:0] cam_data;
  logic        cam_vsync;
  logic        pix_valid;
  logic        pix_ready;
  logic [3:0]  pix_data;
  logic [2:0]  pix_x;
  logic [2:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;
  logic        fb_wr_rst;
  logic        ovf_err;
  logic [7:0]  frame_cnt;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  cam_gray_framer dut (
    .clk(clk), .rst(rst), .cam_dv(cam_dv), .cam_data(cam_data), .cam_vsync(cam_vsync),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_x(pix_x),
    .pix_y(pix_y), .pix_sof(pix_sof), .pix_eol(pix_eol), .fb_wr_rst(fb_wr_rst),
    .ovf_err(ovf_err), .frame_cnt(frame_cnt)
  );

  // Observed tag vector: {valid, sof, eol, y, x}
  function automatic logic [8:0] tags();
    return {pix_valid, pix_sof, pix_eol, pix_y, pix_x};
  endfunction

  function automatic logic [8:0] exp_tags(input int x, input int y, input logic sof);
    return {1'b1, sof, (x == 7), 3'(y), 3'(x)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0; cam_dv = 1'b0; cam_vsync = 1'b0; cam_data = '0; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cam_dv = 1'b1; cam_vsync = 1'b0; cam_data = 16'hFFFF; pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if ({tags(), pix_data} !== 13'd0) begin
      nfail++; $display("FAIL reset_outputs got %h want 0", {tags(), pix_data});
    end
    nvec++;
    if ({fb_wr_rst, ovf_err, frame_cnt} !== 10'd0) begin
      nfail++; $display("FAIL reset_status got %h want 0", {fb_wr_rst, ovf_err, frame_cnt});
    end
    cam_dv = 1'b0;
  endtask

  task automatic test_grey();
    logic [15:0] vec  [7];
    logic [3:0]  expd [7];
    logic [3:0]  p;
    p = 4'd15; vec[0] = {p, 1'b0, p, 2'b0, p, 1'b0}; expd[0] = 4'd15;
    p = 4'd1;  vec[1] = {p, 1'b0, p, 2'b0, p, 1'b0}; expd[1] = 4'd1;
    p = 4'd0;  vec[2] = {p, 1'b0, p, 2'b0, p, 1'b0}; expd[2] = 4'd0;
    vec[3] = 16'hFFFF; expd[3] = 4'd15;
    vec[4] = 16'hF800; expd[4] = 4'd4;
    vec[5] = 16'h07E0; expd[5] = 4'd9;
    vec[6] = 16'h001F; expd[6] = 4'd1;
    apply_reset();
    for (int w = 0; w < 10; w++) begin
      tick();
      cam_dv = (w < 7);
      if (w < 7) cam_data = vec[w];
      @(negedge clk);
      nvec++;
      if (w >= 2 && w < 9) begin
        if (pix_valid !== 1'b1 || pix_data !== expd[w-2]) begin
          nfail++;
          $display("FAIL grey[%0d] got v=%b d=%0d want v=1 d=%0d", w - 2, pix_valid, pix_data,
                   expd[w-2]);
        end
      end else if (pix_valid !== 1'b0) begin
        nfail++; $display("FAIL grey_idle w=%0d got v=%b want 0", w, pix_valid);
      end
    end
  endtask

  task automatic test_frame();
    apply_reset();
    for (int w = 0; w < 69; w++) begin
      tick();
      cam_dv = (w < 65); cam_data = 16'hFFFF;
      @(negedge clk);
      if (w >= 2 && w < 67) begin
        nvec++;
        if (tags() !== exp_tags((w - 2) % 8, ((w - 2) / 8) % 8, ((w - 2) % 64) == 0) ||
            pix_data !== 4'd15) begin
          nfail++;
          $display("FAIL frame_px[%0d] got %h/%0d want %h/15", w - 2, tags(), pix_data,
                   exp_tags((w - 2) % 8, ((w - 2) / 8) % 8, ((w - 2) % 64) == 0));
        end
      end else begin
        nvec++;
        if (pix_valid !== 1'b0) begin
          nfail++; $display("FAIL frame_idle w=%0d got v=%b want 0", w, pix_valid);
        end
      end
      nvec++;
      if (fb_wr_rst !== (w == 64)) begin
        nfail++; $display("FAIL frame_fbrst w=%0d got %b want %b", w, fb_wr_rst, w == 64);
      end
      if (w == 63) begin
        nvec++;
        if (frame_cnt !== 8'd0) begin
          nfail++; $display("FAIL frame_cnt_early got %0d want 0", frame_cnt);
        end
      end
    end
    nvec++;
    if (frame_cnt !== 8'd1) begin
      nfail++; $display("FAIL frame_cnt got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_vsync();
    int k;
    apply_reset();
    for (int w = 0; w < 27; w++) begin
      tick();
      cam_dv = (w < 23); cam_vsync = (w == 20); cam_data = 16'h0000;
      @(negedge clk);
      k = w - 2;
      if (k >= 0 && k < 23) begin
        nvec++;
        if (k < 20 && tags() !== exp_tags(k % 8, k / 8, k == 0)) begin
          nfail++; $display("FAIL vsync_px[%0d] got %h want %h", k, tags(),
                            exp_tags(k % 8, k / 8, k == 0));
        end else if (k >= 20 && tags() !== exp_tags(k - 20, 0, k == 20)) begin
          nfail++; $display("FAIL vsync_px[%0d] got %h want %h", k, tags(),
                            exp_tags(k - 20, 0, k == 20));
        end
      end
      if (w >= 19 && w <= 23) begin
        nvec++;
        if (fb_wr_rst !== (w == 21)) begin
          nfail++; $display("FAIL vsync_fbrst w=%0d got %b want %b", w, fb_wr_rst, w == 21);
        end
      end
    end
    cam_vsync = 1'b0;
    nvec++;
    if (frame_cnt !== 8'd0) begin
      nfail++; $display("FAIL vsync_frame_cnt got %0d want 0", frame_cnt);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int w = 0; w < 15; w++) begin
      tick();
      pix_ready = (w >= 8); cam_dv = (w < 6) || (w == 12); cam_data = 16'hFFFF;
      @(negedge clk);
      nvec++;
      if (w >= 2 && w < 8) begin
        if (tags() !== exp_tags(0, 0, 1'b1)) begin
          nfail++; $display("FAIL ovf_hold w=%0d got %h want %h", w, tags(), exp_tags(0, 0, 1'b1));
        end
      end else if (w >= 8 && w < 12) begin
        if (tags() !== exp_tags(w - 8, 0, w == 8)) begin
          nfail++; $display("FAIL ovf_drain w=%0d got %h want %h", w, tags(),
                            exp_tags(w - 8, 0, w == 8));
        end
      end else if (w == 14) begin
        if (tags() !== exp_tags(6, 0, 1'b0)) begin
          nfail++; $display("FAIL ovf_resume got %h want %h", tags(), exp_tags(6, 0, 1'b0));
        end
      end else if (pix_valid !== 1'b0) begin
        nfail++; $display("FAIL ovf_empty w=%0d got v=%b want 0", w, pix_valid);
      end
      if (w == 5 || w == 6 || w == 14) begin
        nvec++;
        if (ovf_err !== (w != 5)) begin
          nfail++; $display("FAIL ovf_err w=%0d got %b want %b", w, ovf_err, w != 5);
        end
      end
    end
  endtask

  task automatic test_toggle();
    int idx;
    apply_reset();
    for (int w = 0; w < 27; w++) begin
      tick();
      cam_dv = (w < 16); pix_ready = (w % 2 == 0); cam_data = 16'hFFFF;
      @(negedge clk);
      nvec++;
      if (w >= 2 && w <= 24) begin
        idx = (w <= 16) ? (w - 1) / 2 : 9 + 2 * ((w - 17) / 2);
        if (tags() !== exp_tags(idx % 8, idx / 8, idx == 0)) begin
          nfail++; $display("FAIL toggle w=%0d got %h want %h", w, tags(),
                            exp_tags(idx % 8, idx / 8, idx == 0));
        end
      end else if (pix_valid !== 1'b0) begin
        nfail++; $display("FAIL toggle_empty w=%0d got v=%b want 0", w, pix_valid);
      end
    end
    nvec++;
    if (ovf_err !== 1'b1) begin
      nfail++; $display("FAIL toggle_ovf got %b want 1", ovf_err);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int w = 0; w < 68; w++) begin
      tick();
      cam_dv = 1'b1; cam_data = 16'hFFFF;
    end
    tick();
    nvec++;
    if ({pix_valid, frame_cnt} !== {1'b1, 8'd1}) begin
      nfail++; $display("FAIL arst_pre got v=%b fc=%0d want v=1 fc=1", pix_valid, frame_cnt);
    end
    rst = 1'b0;
    #1;
    nvec++;
    if ({tags(), pix_data, fb_wr_rst, ovf_err, frame_cnt} !== 23'd0) begin
      nfail++; $display("FAIL arst_now got %h want 0", {tags(), pix_data, fb_wr_rst, ovf_err,
                                                        frame_cnt});
    end
    cam_dv = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      cam_dv = (w == 0);
      @(negedge clk);
    end
    nvec++;
    if ({tags(), frame_cnt} !== {exp_tags(0, 0, 1'b1), 8'd0}) begin
      nfail++; $display("FAIL arst_first got %h fc=%0d want %h fc=0", tags(), frame_cnt,
                        exp_tags(0, 0, 1'b1));
    end
  endtask

  initial begin
    test_reset();
    test_grey();
    test_frame();
    test_vsync();
    test_overflow();
    test_toggle();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
